// File: rtl/tx_medida_serial.sv
// rtl/tx_medida_serial.sv - 6-character ASCII measurement message over a 7E2 serial line
module tx_medida_serial #(
    parameter int BAUD_DIV = 5208,
    parameter int N_CHARS  = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enviar,
    input  logic [11:0] medida,
    input  logic        dentro,
    output logic        saida_serial,
    output logic        ocupado,
    output logic        pronto,
    output logic [3:0]  db_estado
);

    localparam int CW = $clog2(BAUD_DIV);

    typedef enum logic [3:0] {
        INICIAL   = 4'd0,
        CARREGA   = 4'd1,
        TRANSMITE = 4'd2,
        PROXIMO   = 4'd3,
        FINAL     = 4'd4
    } estado_t;

    estado_t     estado, proximo;
    logic [CW-1:0] baud_cnt;
    logic [3:0]  bit_idx;
    logic [2:0]  char_idx;
    logic [11:0] medida_q;
    logic        dentro_q;
    logic [9:0]  shift;
    logic        tx_q;
    logic [6:0]  char_atual;
    logic        fim_bit, fim_quadro, ultimo_char;

    function automatic logic [6:0] digito(input logic [3:0] n);
        return (n > 4'd9) ? 7'h3F : 7'h30 + {3'b000, n};
    endfunction

    assign fim_bit     = (baud_cnt == CW'(BAUD_DIV - 1));
    // Leave the frame one cycle early so PROXIMO becomes the last cycle of the second stop bit.
    assign fim_quadro  = (bit_idx == 4'd10) && (baud_cnt == CW'(BAUD_DIV - 2));
    assign ultimo_char = (char_idx == 3'(N_CHARS - 1));

    always_comb begin
        char_atual = 7'h23;
        case (char_idx)
            3'd0:    char_atual = digito(medida_q[11:8]);
            3'd1:    char_atual = digito(medida_q[7:4]);
            3'd2:    char_atual = digito(medida_q[3:0]);
            3'd3:    char_atual = 7'h2C;
            3'd4:    char_atual = dentro_q ? 7'h44 : 7'h46;
            default: char_atual = 7'h23;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) estado <= INICIAL;
        else       estado <= proximo;
    end

    always_comb begin
        proximo   = estado;
        ocupado   = (estado != INICIAL);
        pronto    = (estado == FINAL);
        db_estado = estado;
        case (estado)
            INICIAL:   if (enviar) proximo = CARREGA;
            CARREGA:   proximo = TRANSMITE;
            TRANSMITE: if (fim_quadro) proximo = PROXIMO;
            PROXIMO:   proximo = ultimo_char ? FINAL : CARREGA;
            FINAL:     proximo = INICIAL;
            default:   proximo = INICIAL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            char_idx <= '0;
            medida_q <= '0;
            dentro_q <= 1'b0;
            shift    <= '0;
            tx_q     <= 1'b1;
        end else begin
            case (estado)
                INICIAL: begin
                    if (enviar) begin
                        medida_q <= medida;
                        dentro_q <= dentro;
                        tx_q     <= 1'b0;
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        char_idx <= '0;
                    end
                end
                CARREGA: begin
                    // The start bit is already on the line; shift holds the remaining ten bits.
                    shift    <= {2'b11, ^char_atual, char_atual};
                    baud_cnt <= baud_cnt + 1'b1;
                end
                TRANSMITE: begin
                    if (fim_bit) begin
                        baud_cnt <= '0;
                        tx_q     <= shift[0];
                        shift    <= {1'b1, shift[9:1]};
                        bit_idx  <= bit_idx + 4'd1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                PROXIMO: begin
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    char_idx <= char_idx + 3'd1;
                    if (!ultimo_char) tx_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign saida_serial = tx_q;

endmodule

// File: tb/tb_tx_medida_serial.sv
// tb/tb_tx_medida_serial.sv - randomized self-checking bench for tx_medida_serial
module tb_tx_medida_serial;

    localparam int B   = 4;
    localparam int MSG = 66 * B;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enviar = 1'b0;
    logic [11:0] medida = 12'h000;
    logic        dentro = 1'b0;
    logic        saida_serial, ocupado, pronto;
    logic [3:0]  db_estado;

    int tests = 0;
    int fails = 0;

    tx_medida_serial #(.BAUD_DIV(B), .N_CHARS(6)) dut (
        .clock(clock), .reset(reset), .enviar(enviar), .medida(medida), .dentro(dentro),
        .saida_serial(saida_serial), .ocupado(ocupado), .pronto(pronto), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    function automatic logic [6:0] model_char(input int idx, input logic [11:0] m, input logic d);
        logic [3:0] n;
        n = 4'd0;
        if (idx == 0) n = m[11:8];
        if (idx == 1) n = m[7:4];
        if (idx == 2) n = m[3:0];
        if (idx < 3) return (n > 4'd9) ? 7'h3F : 7'h30 + {3'b000, n};
        if (idx == 3) return 7'h2C;
        if (idx == 4) return d ? 7'h44 : 7'h46;
        return 7'h23;
    endfunction

    // Expected line level at cycle s counted from the first start-bit cycle.
    function automatic logic model_line(input int s, input logic [11:0] m, input logic d);
        int c, b;
        logic [6:0] ch;
        c  = s / (11 * B);
        b  = (s / B) % 11;
        ch = model_char(c, m, d);
        if (b == 0) return 1'b0;
        if (b <= 7) return ch[b-1];
        if (b == 8) return ($countones(ch) % 2) == 1;
        return 1'b1;
    endfunction

    task automatic run_message(input logic [11:0] m, input logic d, input bit disturb);
        int wave_err = 0, first_err = -1, busy_err = 0;
        int pr_cnt = 0, pr_at = -1;
        bit fell = 0;
        logic [6:0] got [6];
        for (int c = 0; c < 6; c++) got[c] = 7'h00;
        @(negedge clock);
        enviar = 1'b1; medida = m; dentro = d;
        @(negedge clock);
        enviar = 1'b0; medida = 12'($urandom); dentro = 1'($urandom);
        for (int i = 0; i < MSG; i++) begin
            if (saida_serial !== model_line(i, m, d)) begin
                wave_err++;
                if (first_err < 0) first_err = i;
            end
            if ((i % B) == B / 2 && ((i / B) % 11) >= 1 && ((i / B) % 11) <= 7)
                got[i / (11 * B)][((i / B) % 11) - 1] = saida_serial;
            if (pronto === 1'b1) begin pr_cnt++; pr_at = i; end
            if (ocupado !== 1'b1) busy_err++;
            enviar = disturb && (i == MSG / 2);
            if (enviar) medida = 12'h999;
            @(negedge clock);
        end
        enviar = 1'b0;
        for (int j = 0; j < 4 && !fell; j++) begin
            if (pronto === 1'b1) begin pr_cnt++; pr_at = MSG + j; end
            else if (pr_cnt > 0 && ocupado === 1'b0) fell = 1;
            if (!fell) @(negedge clock);
        end
        tests++;
        if (wave_err !== 0) begin
            fails++;
            $display("FAIL wave m=%h d=%0d: %0d bad cycles, first at %0d, required 0", m, d, wave_err, first_err);
        end
        for (int c = 0; c < 6; c++) begin
            tests++;
            if (got[c] !== model_char(c, m, d)) begin
                fails++;
                $display("FAIL char%0d m=%h: got %h required %h", c, m, got[c], model_char(c, m, d));
            end
        end
        tests++;
        if (pr_cnt !== 1 || pr_at < MSG - 1 || pr_at > MSG + 1) begin
            fails++;
            $display("FAIL pronto m=%h: %0d pulses at %0d, required 1 pulse at %0d+-1", m, pr_cnt, pr_at, MSG);
        end
        tests++;
        if (busy_err !== 0) begin
            fails++;
            $display("FAIL ocupado_during m=%h: low for %0d cycles, required 0", m, busy_err);
        end
        tests++;
        if (!fell || saida_serial !== 1'b1) begin
            fails++;
            $display("FAIL ocupado_fall m=%h: fell=%0d line=%b, required fell=1 line=1", m, fell, saida_serial);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        tests++;
        if (saida_serial !== 1'b1 || ocupado !== 1'b0 || pronto !== 1'b0 || db_estado !== 4'd0) begin
            fails++;
            $display("FAIL reset: line=%b ocupado=%b pronto=%b estado=%0d, required 1 0 0 0",
                     saida_serial, ocupado, pronto, db_estado);
        end
        reset = 1'b0;
    endtask

    task automatic test_idle();
        int bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clock);
            if (saida_serial !== 1'b1 || db_estado !== 4'd0 || ocupado !== 1'b0) bad++;
        end
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL idle: %0d cycles not idle, required 0", bad);
        end
    endtask

    task automatic test_fixed();
        run_message(12'h100, 1'b0, 1'b0);
        run_message(12'h075, 1'b1, 1'b0);
        run_message(12'h0A5, 1'($urandom), 1'b0);
    endtask

    task automatic test_back_to_back();
        run_message(12'h123, 1'b0, 1'b1);
        run_message(12'h999, 1'b1, 1'b0);
    endtask

    task automatic test_reset_abort();
        int bad = 0;
        @(negedge clock);
        enviar = 1'b1; medida = 12'h246; dentro = 1'b1;
        @(negedge clock);
        enviar = 1'b0;
        repeat (2 * 11 * B + 5) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        tests++;
        if (saida_serial !== 1'b1 || ocupado !== 1'b0 || pronto !== 1'b0 || db_estado !== 4'd0) begin
            fails++;
            $display("FAIL abort: line=%b ocupado=%b pronto=%b estado=%0d, required 1 0 0 0",
                     saida_serial, ocupado, pronto, db_estado);
        end
        reset = 1'b0;
        for (int i = 0; i < 5 * MSG / 4; i++) begin
            @(negedge clock);
            if (pronto !== 1'b0 || saida_serial !== 1'b1 || ocupado !== 1'b0) bad++;
        end
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL abort_quiet: %0d active cycles after abort, required 0", bad);
        end
        run_message(12'(($urandom % 10) << 8 | ($urandom % 10) << 4 | ($urandom % 10)), 1'($urandom), 1'b0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++)
            run_message(12'($urandom), 1'($urandom), 1'b0);
    endtask

    initial begin
        test_reset();
        test_idle();
        test_fixed();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
